// File: rtl/wb_trap_ctrl.sv
// Write-back trap controller: machine-mode trap CSRs, trap/MRET sequencing, fetch redirect.
// Optional vectored interrupt mode is enabled by defining WB_TRAP_VECTORED_EN.
module wb_trap_ctrl #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     NUM_XINT    = 4,
   parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     instr_i,
   input  logic [3:0]      exc_i,
   input  logic [XLEN-1:0] exc_tval_i,
   input  logic            is_ecall_i,
   input  logic            is_ebreak_i,
   input  logic            is_mret_i,
   input  logic            csr_we_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic [XLEN-1:0] csr_rdata_o,
   input  logic            xint_meip_i,
   input  logic            xint_mtip_i,
   input  logic            xint_msip_i,
   input  logic [NUM_XINT-1:0] xint_plat_i,
   output logic            retire_o,
   output logic            flush_o,
   output logic [XLEN-1:0] trap_pc_o
);

   typedef enum logic [1:0] {StIdle, StSave, StJump} state_e;

`ifdef WB_TRAP_VECTORED_EN
   localparam logic [XLEN-1:0] MtvecRst = {MTVEC_RESET[XLEN-1:2], 1'b0, MTVEC_RESET[0]};
`else
   localparam logic [XLEN-1:0] MtvecRst = {MTVEC_RESET[XLEN-1:2], 2'b00};
`endif

   state_e          state_q, state_d;
   logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
   logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
   logic [XLEN-1:0] pend_cause_q, pend_cause_d, pend_tval_q, pend_tval_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d, target_q, target_d;

   logic [XLEN-1:0] mip, mie_mask, irq_en, trap_cause, trap_tval, trap_target, base;
   logic [4:0]      int_code, exc_code;
   logic            int_pend, exc_any;

   always_comb begin
      mip = '0;
      mip[3] = xint_msip_i;
      mip[7] = xint_mtip_i;
      mip[11] = xint_meip_i;
      mip[16 +: NUM_XINT] = xint_plat_i;
      mie_mask = '0;
      mie_mask[3] = 1'b1;
      mie_mask[7] = 1'b1;
      mie_mask[11] = 1'b1;
      mie_mask[16 +: NUM_XINT] = '1;
   end

   assign irq_en   = mie_q & mip;
   assign int_pend = mst_mie_q & (|irq_en);

   // Later assignments win, so the loop runs from lowest to highest priority.
   always_comb begin
      int_code = 5'd0;
      for (int k = NUM_XINT - 1; k >= 0; k--) begin
         if (irq_en[16 + k]) int_code = 5'(16 + k);
      end
      if (irq_en[7])  int_code = 5'd7;
      if (irq_en[3])  int_code = 5'd3;
      if (irq_en[11]) int_code = 5'd11;
   end

   always_comb begin
      exc_any   = (|exc_i) | is_ecall_i | is_ebreak_i;
      exc_code  = 5'd0;
      trap_tval = '0;
      if (exc_i[0]) begin
         exc_code  = 5'd0;
         trap_tval = exc_tval_i;
      end else if (exc_i[1]) begin
         exc_code  = 5'd2;
         trap_tval = XLEN'(instr_i);
      end else if (is_ebreak_i) begin
         exc_code  = 5'd3;
         trap_tval = pc_i;
      end else if (exc_i[2]) begin
         exc_code  = 5'd4;
         trap_tval = exc_tval_i;
      end else if (exc_i[3]) begin
         exc_code  = 5'd6;
         trap_tval = exc_tval_i;
      end else if (is_ecall_i) begin
         exc_code  = 5'd11;
         trap_tval = '0;
      end
      trap_cause = '0;
      if (int_pend) begin
         trap_cause[XLEN-1] = 1'b1;
         trap_cause[4:0]    = int_code;
         trap_tval          = '0;
      end else begin
         trap_cause[4:0]    = exc_code;
      end
      base        = {mtvec_q[XLEN-1:2], 2'b00};
      trap_target = base;
`ifdef WB_TRAP_VECTORED_EN
      if (int_pend && mtvec_q[0]) trap_target = base + (XLEN'(int_code) << 2);
`endif
   end

   always_comb begin
      csr_rdata_o = '0;
      case (csr_addr_i)
         12'h300: begin
            csr_rdata_o[12:11] = 2'b11;
            csr_rdata_o[7]     = mst_mpie_q;
            csr_rdata_o[3]     = mst_mie_q;
         end
         12'h304: csr_rdata_o = mie_q;
         12'h305: csr_rdata_o = mtvec_q;
         12'h341: csr_rdata_o = mepc_q;
         12'h342: csr_rdata_o = mcause_q;
         12'h343: csr_rdata_o = mtval_q;
         12'h344: csr_rdata_o = mip;
         default: csr_rdata_o = '0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mst_mie_d    = mst_mie_q;
      mst_mpie_d   = mst_mpie_q;
      mie_d        = mie_q;
      mtvec_d      = mtvec_q;
      mepc_d       = mepc_q;
      mcause_d     = mcause_q;
      mtval_d      = mtval_q;
      pend_cause_d = pend_cause_q;
      pend_tval_d  = pend_tval_q;
      pend_pc_d    = pend_pc_q;
      target_d     = target_q;
      ready_o      = 1'b0;
      retire_o     = 1'b0;
      flush_o      = 1'b0;
      trap_pc_o    = '0;
      case (state_q)
         StIdle: begin
            ready_o = 1'b1;
            if (valid_i) begin
               if (int_pend || exc_any) begin
                  pend_cause_d = trap_cause;
                  pend_tval_d  = trap_tval;
                  pend_pc_d    = pc_i;
                  target_d     = trap_target;
                  state_d      = StSave;
               end else if (is_mret_i) begin
                  target_d   = mepc_q;
                  mst_mie_d  = mst_mpie_q;
                  mst_mpie_d = 1'b1;
                  retire_o   = 1'b1;
                  state_d    = StJump;
               end else begin
                  retire_o = 1'b1;
                  if (csr_we_i) begin
                     case (csr_addr_i)
                        12'h300: begin
                           mst_mie_d  = csr_wdata_i[3];
                           mst_mpie_d = csr_wdata_i[7];
                        end
                        12'h304: mie_d = csr_wdata_i & mie_mask;
`ifdef WB_TRAP_VECTORED_EN
                        // Modes 2/3 are reserved: keep the current mode.
                        12'h305: mtvec_d = csr_wdata_i[1] ?
                                           {csr_wdata_i[XLEN-1:2], mtvec_q[1:0]} :
                                           {csr_wdata_i[XLEN-1:2], 1'b0, csr_wdata_i[0]};
`else
                        12'h305: mtvec_d = {csr_wdata_i[XLEN-1:2], 2'b00};
`endif
                        12'h341: mepc_d   = {csr_wdata_i[XLEN-1:2], 2'b00};
                        12'h342: mcause_d = csr_wdata_i;
                        12'h343: mtval_d  = csr_wdata_i;
                        default: ;
                     endcase
                  end
               end
            end
         end
         StSave: begin
            mepc_d     = {pend_pc_q[XLEN-1:2], 2'b00};
            mcause_d   = pend_cause_q;
            mtval_d    = pend_tval_q;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            state_d    = StJump;
         end
         StJump: begin
            flush_o   = 1'b1;
            trap_pc_o = target_q;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= StIdle;
         mst_mie_q    <= 1'b0;
         mst_mpie_q   <= 1'b0;
         mie_q        <= '0;
         mtvec_q      <= MtvecRst;
         mepc_q       <= '0;
         mcause_q     <= '0;
         mtval_q      <= '0;
         pend_cause_q <= '0;
         pend_tval_q  <= '0;
         pend_pc_q    <= '0;
         target_q     <= '0;
      end else begin
         state_q      <= state_d;
         mst_mie_q    <= mst_mie_d;
         mst_mpie_q   <= mst_mpie_d;
         mie_q        <= mie_d;
         mtvec_q      <= mtvec_d;
         mepc_q       <= mepc_d;
         mcause_q     <= mcause_d;
         mtval_q      <= mtval_d;
         pend_cause_q <= pend_cause_d;
         pend_tval_q  <= pend_tval_d;
         pend_pc_q    <= pend_pc_d;
         target_q     <= target_d;
      end
   end

endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Directed self-checking bench for wb_trap_ctrl (default build, plus vectored checks
// when WB_TRAP_VECTORED_EN is defined).
module tb_wb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, ready, ecall, ebreak, mret, csr_we;
   logic [31:0] pc, instr, exc_tval, csr_wdata, csr_rdata, trap_pc;
   logic [3:0]  exc;
   logic [11:0] csr_addr;
   logic        meip, mtip, msip, retire, flush;
   logic [3:0]  plat;

   int total = 0;
   int bad   = 0;

   wb_trap_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .valid_i     (valid),
      .ready_o     (ready),
      .pc_i        (pc),
      .instr_i     (instr),
      .exc_i       (exc),
      .exc_tval_i  (exc_tval),
      .is_ecall_i  (ecall),
      .is_ebreak_i (ebreak),
      .is_mret_i   (mret),
      .csr_we_i    (csr_we),
      .csr_addr_i  (csr_addr),
      .csr_wdata_i (csr_wdata),
      .csr_rdata_o (csr_rdata),
      .xint_meip_i (meip),
      .xint_mtip_i (mtip),
      .xint_msip_i (msip),
      .xint_plat_i (plat),
      .retire_o    (retire),
      .flush_o     (flush),
      .trap_pc_o   (trap_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr_instr();
      valid = 0; pc = 0; instr = 32'h13; exc = 0; exc_tval = 0;
      ecall = 0; ebreak = 0; mret = 0; csr_we = 0; csr_wdata = 0;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      csr_addr = a;
      #1 d = csr_rdata;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      valid = 1; csr_we = 1; csr_addr = a; csr_wdata = d;
      #1 check("wr_retire", {31'b0, retire}, 32'd1);
      @(posedge clk); #1;
      clr_instr();
   endtask

   // Instruction inputs are already applied; walks SAVE and JUMP and checks the CSRs.
   task automatic do_trap(input string tag, input logic [31:0] exp_pc,
                          input logic [31:0] exp_cause, input logic [31:0] exp_tval,
                          input logic [31:0] exp_epc);
      logic [31:0] d;
      #1 check({tag, "_noretire"}, {31'b0, retire}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_save_ready"}, {31'b0, ready}, 32'd0);
      check({tag, "_save_flush"}, {31'b0, flush}, 32'd0);
      check({tag, "_held_noretire"}, {31'b0, retire}, 32'd0);
      clr_instr();
      @(posedge clk); #1;
      check({tag, "_flush"}, {31'b0, flush}, 32'd1);
      check({tag, "_trap_pc"}, trap_pc, exp_pc);
      rd(12'h342, d); check({tag, "_mcause"}, d, exp_cause);
      rd(12'h343, d); check({tag, "_mtval"}, d, exp_tval);
      rd(12'h341, d); check({tag, "_mepc"}, d, exp_epc);
      @(posedge clk); #1;
      check({tag, "_flush_end"}, {31'b0, flush}, 32'd0);
      check({tag, "_ready_end"}, {31'b0, ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      rst_n = 0; csr_addr = 0; meip = 0; mtip = 0; msip = 0; plat = 0;
      clr_instr();
      #2;
      check("rst_flush", {31'b0, flush}, 32'd0);
      check("rst_trap_pc", trap_pc, 32'd0);
      check("rst_ready", {31'b0, ready}, 32'd1);
      check("rst_retire", {31'b0, retire}, 32'd0);
      #10 rst_n = 1;
      @(posedge clk); #1;

      // Ordinary instruction retires
      valid = 1; pc = 32'h10;
      #1 check("plain_retire", {31'b0, retire}, 32'd1);
      check("plain_flush", {31'b0, flush}, 32'd0);
      rd(12'h342, d); check("rst_mcause", d, 32'd0);
      rd(12'h305, d); check("rst_mtvec", d, 32'h100);
      rd(12'h300, d); check("rst_mstatus", d, 32'h1800);
      @(posedge clk); #1;
      clr_instr();

      // Illegal instruction with MIE=1 beforehand
      csr_write(12'h300, 32'h8);
      valid = 1; pc = 32'h40; instr = 32'hFFFF_FFFF; exc = 4'b0010;
      do_trap("illegal", 32'h100, 32'd2, 32'hFFFF_FFFF, 32'h40);
      rd(12'h300, d); check("illegal_mstatus", d, 32'h1880);

      // MRET: redirect to mepc one cycle after acceptance
      valid = 1; mret = 1; pc = 32'h104;
      #1 check("mret_retire", {31'b0, retire}, 32'd1);
      @(posedge clk); #1;
      clr_instr();
      check("mret_flush", {31'b0, flush}, 32'd1);
      check("mret_trap_pc", trap_pc, 32'h40);
      rd(12'h300, d); check("mret_mstatus", d, 32'h1888);
      @(posedge clk); #1;
      check("mret_flush_end", {31'b0, flush}, 32'd0);

      // Timer interrupt beats a load misalign on the same instruction
      csr_write(12'h304, 32'h80);
      mtip = 1;
      valid = 1; pc = 32'h80; exc = 4'b0100; exc_tval = 32'h1234;
      do_trap("irq_vs_ldmis", 32'h100, 32'h8000_0007, 32'd0, 32'h80);
      mtip = 0;

      // Interrupt priority: MEI > MSI > plat
      csr_write(12'h304, 32'h4_0888 | 32'hF000);
      rd(12'h304, d); check("mie_mask", d, 32'h4_0888);
      meip = 1; msip = 1; plat = 4'b0100;
      rd(12'h344, d); check("mip_read", d, 32'h4_0808);
      csr_write(12'h300, 32'h8);  // writing instruction itself must not trap
      check("mie_wr_no_trap", {31'b0, ready}, 32'd1);
      valid = 1; pc = 32'h90;
      do_trap("irq_meip", 32'h100, 32'h8000_000B, 32'd0, 32'h90);
      meip = 0;
      csr_write(12'h300, 32'h8);
      valid = 1; pc = 32'h94;
      do_trap("irq_msip", 32'h100, 32'h8000_0003, 32'd0, 32'h94);
      msip = 0; plat = 0;

      // EBREAK outranks store misalign; ECALL has zero mtval
      valid = 1; pc = 32'h300; ebreak = 1; exc = 4'b1000; exc_tval = 32'h777;
      do_trap("ebreak", 32'h100, 32'd3, 32'h300, 32'h300);
      valid = 1; pc = 32'h204; ecall = 1;
      do_trap("ecall", 32'h100, 32'd11, 32'd0, 32'h204);

      // CSR edge cases
      csr_write(12'h341, 32'h1003);
      rd(12'h341, d); check("mepc_align", d, 32'h1000);
      csr_write(12'h123, 32'hDEAD_BEEF);
      rd(12'h123, d); check("unmapped_read", d, 32'd0);

`ifdef WB_TRAP_VECTORED_EN
      csr_write(12'h305, 32'h101);
      rd(12'h305, d); check("mtvec_vec", d, 32'h101);
      csr_write(12'h305, 32'h103);
      rd(12'h305, d); check("mtvec_keep_mode", d, 32'h101);
      csr_write(12'h304, 32'h80);
      csr_write(12'h300, 32'h8);
      mtip = 1;
      valid = 1; pc = 32'hA0;
      do_trap("vec_mti", 32'h11C, 32'h8000_0007, 32'd0, 32'hA0);
      mtip = 0;
      valid = 1; pc = 32'hA4; ecall = 1;
      do_trap("vec_ecall", 32'h100, 32'd11, 32'd0, 32'hA4);
`else
      csr_write(12'h305, 32'h203);
      rd(12'h305, d); check("mtvec_mode_ro", d, 32'h200);
      valid = 1; pc = 32'hA4; ecall = 1;
      do_trap("new_base", 32'h200, 32'd11, 32'd0, 32'hA4);
`endif

      // Reset in the middle of a trap sequence
      valid = 1; pc = 32'h500; exc = 4'b0010;
      @(posedge clk); #1;
      clr_instr();
      rst_n = 0;
      #1 check("midrst_ready", {31'b0, ready}, 32'd1);
      check("midrst_flush", {31'b0, flush}, 32'd0);
      rd(12'h342, d); check("midrst_mcause", d, 32'd0);
      rd(12'h305, d); check("midrst_mtvec", d, 32'h100);
      rd(12'h341, d); check("midrst_mepc", d, 32'd0);
      #1 rst_n = 1;
      @(posedge clk); #1;
      check("postrst_flush", {31'b0, flush}, 32'd0);
      @(posedge clk); #1;
      check("postrst_flush2", {31'b0, flush}, 32'd0);
      check("postrst_ready", {31'b0, ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
